// File: rtl/ipc_pkg.sv
// Shared types and constants for the host-side IPC serial link.
package ipc_pkg;

    // Transfer sequencer states, one handshake slot per bit.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_NEXT    = 3'd5
    } ipc_state_e;

    // Encodings of the nbits select input.
    localparam logic LEN4 = 1'b0;
    localparam logic LEN8 = 1'b1;

    // Default comctrl edge timeout (ce ticks) and strobe filter depth.
    localparam logic [15:0] DEF_TIMEOUT = 16'd4096;
    localparam int          DEF_FILTER  = 2;

    // Number of handshake slots for a given length select.
    function automatic logic [3:0] bitCount(input logic nbits);
        logic [3:0] n;
        n = (nbits == LEN8) ? 4'd8 : 4'd4;
        return n;
    endfunction

    // Level driven onto the wired-AND comdata line in each state.
    // Low requests a slot, the tx bit is presented around the strobe,
    // and the line is released everywhere else.
    function automatic logic comdataLevel(input ipc_state_e st, input logic txBit);
        logic lvl;
        lvl = 1'b1;
        case (st)
            ST_REQ, ST_WAIT_LO: lvl = 1'b0;
            ST_DATA, ST_WAIT_HI: lvl = txBit;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/ipc_strobe_filter.sv
// Debounce filter for an active-low strobe pin: the filtered level only
// follows the pin once it has held a new value for FILTER consecutive
// ce samples, and single-ce fall/rise events mark each accepted change.
module ipc_strobe_filter
    import ipc_pkg::*;
#(
    parameter int FILTER = DEF_FILTER
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ce_i,
    input  logic strobe_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Count consecutive disagreeing samples and flip the level when the
    // run is long enough; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (ce_i) begin
            if (strobe_i == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                accept  = 1'b1;
                level_d = strobe_i;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_o = level_q;
        fall_o  = accept & level_q;
        rise_o  = accept & ~level_q;
    end

    // Filter state; the strobe idles high so the level resets high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ipc_link.sv
// Host-side IPC serial engine: shifts a 4- or 8-bit command MSB-first to
// the 8049 over the wired-AND comdata line, one bit per comctrl strobe,
// and collects the reply bit returned in each slot.
module ipc_link
    import ipc_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = DEF_TIMEOUT,
    parameter int          FILTER  = DEF_FILTER
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ce_11m_i,
    input  logic       start_i,
    input  logic       nbits_i,
    input  logic [7:0] tx_data_i,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       timeout_o,
    input  logic       comctrl_i,
    output logic       comdata_out_o,
    input  logic       comdata_in_i
);

    ipc_state_e  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [15:0] toCnt_q, toCnt_d;
    logic [7:0]  rxData_q, rxData_d;
    logic        startPend_q, startPend_d;
    logic        timeout_q, timeout_d;
    logic        comdata_q, comdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        ctlF;
    logic        ctlFall;
    logic        ctlRise;

    ipc_strobe_filter #(
        .FILTER (FILTER)
    ) u_ctl_filter (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .ce_i     (ce_11m_i),
        .strobe_i (comctrl_i),
        .level_o  (ctlF),
        .fall_o   (ctlFall),
        .rise_o   (ctlRise)
    );

    // Sequencer next state. Everything advances on ce only, except that a
    // start seen between ce ticks is parked in a pending flag. The line
    // level and busy are derived from the next state so they are registered
    // with it and the wired-AND line never sees decode glitches. REQ holds
    // off while ipc still has its strobe down, bounded by the same timeout.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        toCnt_d     = toCnt_q;
        rxData_d    = rxData_q;
        startPend_d = startPend_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;

        if (ce_11m_i) begin
            startPend_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i || startPend_q) begin
                        shift_d   = (nbits_i == LEN4) ? {tx_data_i[3:0], 4'h0} : tx_data_i;
                        bitCnt_d  = bitCount(nbits_i);
                        rxData_d  = 8'h00;
                        timeout_d = 1'b0;
                        toCnt_d   = 16'd0;
                        state_d   = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ctlF) begin
                        toCnt_d = 16'd0;
                        state_d = ST_WAIT_LO;
                    end else if (toCnt_q == TIMEOUT - 16'd1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        toCnt_d = toCnt_q + 16'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (ctlFall) begin
                        state_d = ST_DATA;
                    end else if (toCnt_q == TIMEOUT - 16'd1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        toCnt_d = toCnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    toCnt_d = 16'd0;
                    state_d = ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (ctlRise) begin
                        rxData_d = {rxData_q[6:0], comdata_in_i};
                        shift_d  = {shift_q[6:0], 1'b0};
                        bitCnt_d = bitCnt_q - 4'd1;
                        state_d  = ST_NEXT;
                    end else if (toCnt_q == TIMEOUT - 16'd1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        toCnt_d = toCnt_q + 16'd1;
                    end
                end
                ST_NEXT: begin
                    if (bitCnt_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (start_i && (state_q == ST_IDLE)) begin
            startPend_d = 1'b1;
        end

        comdata_d = comdataLevel(state_d, shift_d[7]);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; reset releases comdata immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            bitCnt_q    <= 4'd0;
            toCnt_q     <= 16'd0;
            rxData_q    <= 8'h00;
            startPend_q <= 1'b0;
            timeout_q   <= 1'b0;
            comdata_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            toCnt_q     <= toCnt_d;
            rxData_q    <= rxData_d;
            startPend_q <= startPend_d;
            timeout_q   <= timeout_d;
            comdata_q   <= comdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rx_data_o     = rxData_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign comdata_out_o = comdata_q;

endmodule
